// File: rtl/vadd_accum_disp.sv
// vadd_accum_disp: strobed add/sub accumulator with sticky overflow and a
// multiplexed active-low seven-segment hex display scanner.
module vadd_accum_disp #(
  parameter int WIDTH    = 8,
  parameter int SCAN_DIV = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   a,
  input  logic               add_stb,
  input  logic               mode,
  input  logic               clr,
  output logic [WIDTH-1:0]   sum,
  output logic               oflow,
  output logic [6:0]         seg_L,
  output logic [WIDTH/4-1:0] an_L
);
  localparam int DIGITS = WIDTH / 4;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;

  logic [WIDTH-1:0]  acc_q, acc_d, shifted;
  logic              oflow_q, oflow_d, stb_q, stb_d, rise, tc;
  logic [PW-1:0]     pre_q, pre_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [WIDTH:0]    r;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    r        = mode ? {1'b0, acc_q} - {1'b0, a} : {1'b0, acc_q} + {1'b0, a};
    rise     = add_stb & ~stb_q;
    acc_d    = clr ? '0 : rise ? r[WIDTH-1:0] : acc_q;
    oflow_d  = clr ? 1'b0 : oflow_q | (rise & r[WIDTH]);
    stb_d    = add_stb;
    tc       = pre_q == PW'(SCAN_DIV - 1);
    pre_d    = tc ? '0 : pre_q + PW'(1);
    idx_d    = tc ? (idx_q == IW'(DIGITS - 1) ? '0 : idx_q + IW'(1)) : idx_q;
    // Display samples the current digit so segments and anode move together
    shifted  = acc_q >> {idx_q, 2'b00};
    seg_d    = hex7(shifted[3:0]);
    an_d     = ~(DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q   <= '0;
      oflow_q <= 1'b0;
      stb_q   <= 1'b0;
      pre_q   <= '0;
      idx_q   <= '0;
      an_q    <= ~DIGITS'(1);
      seg_q   <= 7'b1000000;
    end else begin
      acc_q   <= acc_d;
      oflow_q <= oflow_d;
      stb_q   <= stb_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign sum   = acc_q;
  assign oflow = oflow_q;
  assign seg_L = seg_q;
  assign an_L  = an_q;
endmodule
